multi_edge_one_shot: RTL and testbench

MULTI_EDGE_ONE_SHOT -- requirements
Module: multi_edge_one_shot

---
 rtl/multi_edge_one_shot.sv | 132 +++++++++++++
 tb/tb_multi_edge_one_shot.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_one_shot.sv
// Per-channel synchronizer, debouncer and non-retriggerable one-shot for raw
// button/switch inputs, with a shared registered Busy flag.
module multi_edge_one_shot #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 1,
    parameter int EDGE_MODE       = 0
) (
    input  logic                CLOCK,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] InputPulse,
    output logic [CHANNELS-1:0] OneShot,
    output logic [CHANNELS-1:0] Level,
    output logic                Busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_t;

    // The debounce counter only ever holds DEBOUNCE_CYCLES-1; one extra bit on
    // the increment lets the terminal compare happen without wrapping.
    localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (PULSE_CYCLES < 2) ? 1 : $clog2(PULSE_CYCLES);

    localparam int DEB_INT   = DEBOUNCE_CYCLES;
    localparam int PLAST_INT = PULSE_CYCLES - 1;
    localparam logic [DW:0]   DEB_LIMIT  = DEB_INT[DW:0];
    localparam logic [PW-1:0] PULSE_LAST = PLAST_INT[PW-1:0];

    localparam bit RISE_EN = (EDGE_MODE != 1);
    localparam bit FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    logic [CHANNELS-1:0] s1_q, s1_d;
    logic [CHANNELS-1:0] s2_q, s2_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] edge_q, edge_d;
    logic [CHANNELS-1:0] one_shot_q, one_shot_d;
    logic                busy_q, busy_d;

    logic [DW-1:0] deb_cnt_q   [CHANNELS];
    logic [DW-1:0] deb_cnt_d   [CHANNELS];
    logic [PW-1:0] pulse_cnt_q [CHANNELS];
    logic [PW-1:0] pulse_cnt_d [CHANNELS];
    pulse_state_t  state_q     [CHANNELS];
    pulse_state_t  state_d     [CHANNELS];

    // Next-state logic. An accepted edge is latched for one clock in edge_q so
    // that the pulse starts the cycle after Level changes.
    always_comb begin
        s1_d   = InputPulse;
        s2_d   = s1_q;
        busy_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            logic [DW:0] deb_next;
            deb_next       = {1'b0, deb_cnt_q[c]} + 1'b1;
            level_d[c]     = level_q[c];
            edge_d[c]      = 1'b0;
            deb_cnt_d[c]   = '0;
            state_d[c]     = state_q[c];
            pulse_cnt_d[c] = pulse_cnt_q[c];

            if (s2_q[c] != level_q[c]) begin
                if (deb_next == DEB_LIMIT) begin
                    level_d[c] = s2_q[c];
                    edge_d[c]  = s2_q[c] ? RISE_EN : FALL_EN;
                end else begin
                    deb_cnt_d[c] = deb_next[DW-1:0];
                end
            end

            // Edges arriving while ACTIVE are simply dropped.
            case (state_q[c])
                IDLE: begin
                    if (edge_q[c]) begin
                        state_d[c]     = ACTIVE;
                        pulse_cnt_d[c] = '0;
                    end
                end
                ACTIVE: begin
                    if (pulse_cnt_q[c] == PULSE_LAST) begin
                        state_d[c]     = IDLE;
                        pulse_cnt_d[c] = '0;
                    end else begin
                        pulse_cnt_d[c] = pulse_cnt_q[c] + 1'b1;
                    end
                end
                default: begin
                    state_d[c]     = IDLE;
                    pulse_cnt_d[c] = '0;
                end
            endcase

            one_shot_d[c] = (state_d[c] == ACTIVE);
            busy_d        = busy_d | one_shot_d[c];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            level_q    <= '0;
            edge_q     <= '0;
            one_shot_q <= '0;
            busy_q     <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                deb_cnt_q[c]   <= '0;
                pulse_cnt_q[c] <= '0;
                state_q[c]     <= IDLE;
            end
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            level_q    <= level_d;
            edge_q     <= edge_d;
            one_shot_q <= one_shot_d;
            busy_q     <= busy_d;
            for (int c = 0; c < CHANNELS; c++) begin
                deb_cnt_q[c]   <= deb_cnt_d[c];
                pulse_cnt_q[c] <= pulse_cnt_d[c];
                state_q[c]     <= state_d[c];
            end
        end
    end

    assign OneShot = one_shot_q;
    assign Level   = level_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_multi_edge_one_shot.sv
// Drives four differently parameterised one-shot instances from one stimulus
// stream and compares each against a window-based reference model.
module tb_multi_edge_one_shot;

    localparam int NCFG = 4;
    localparam int D_TAB [NCFG] = '{4, 3, 1, 2};
    localparam int P_TAB [NCFG] = '{1, 3, 8, 5};
    localparam int M_TAB [NCFG] = '{0, 2, 1, 3};

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] input_pulse;
    logic [3:0] dut_os    [NCFG];
    logic [3:0] dut_level [NCFG];
    logic       dut_busy  [NCFG];

    always #5 clock = ~clock;

    multi_edge_one_shot #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(1), .EDGE_MODE(0)) u_cfg0 (
        .CLOCK(clock), .Reset(reset), .InputPulse(input_pulse),
        .OneShot(dut_os[0]), .Level(dut_level[0]), .Busy(dut_busy[0]));
    multi_edge_one_shot #(.CHANNELS(4), .DEBOUNCE_CYCLES(3), .PULSE_CYCLES(3), .EDGE_MODE(2)) u_cfg1 (
        .CLOCK(clock), .Reset(reset), .InputPulse(input_pulse),
        .OneShot(dut_os[1]), .Level(dut_level[1]), .Busy(dut_busy[1]));
    multi_edge_one_shot #(.CHANNELS(4), .DEBOUNCE_CYCLES(1), .PULSE_CYCLES(8), .EDGE_MODE(1)) u_cfg2 (
        .CLOCK(clock), .Reset(reset), .InputPulse(input_pulse),
        .OneShot(dut_os[2]), .Level(dut_level[2]), .Busy(dut_busy[2]));
    multi_edge_one_shot #(.CHANNELS(4), .DEBOUNCE_CYCLES(2), .PULSE_CYCLES(5), .EDGE_MODE(3)) u_cfg3 (
        .CLOCK(clock), .Reset(reset), .InputPulse(input_pulse),
        .OneShot(dut_os[3]), .Level(dut_level[3]), .Busy(dut_busy[3]));

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Reference state: raw input history (index 0 = value at the latest edge),
    // and per config/channel the debounced level plus pulse start/end edges.
    bit hist     [4][16];
    bit m_level  [NCFG][4];
    bit m_pend   [NCFG][4];
    bit m_os     [NCFG][4];
    int m_start  [NCFG][4];
    int m_last   [NCFG][4];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cycle);
        end
    endtask

    // Level flips once the synchronised input (input two edges back) has
    // disagreed with it for D consecutive edges; a pulse covers P edges
    // starting one edge after an accepted flip, unless one is already running.
    task automatic modelStep(input logic rst, input logic [3:0] inp);
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 16; i++) hist[c][i] = 1'b0;
                for (int g = 0; g < NCFG; g++) begin
                    m_level[g][c] = 1'b0;
                    m_pend[g][c]  = 1'b0;
                    m_os[g][c]    = 1'b0;
                    m_start[g][c] = 0;
                    m_last[g][c]  = -1;
                end
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                for (int i = 15; i > 0; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = inp[c];
            end
            for (int g = 0; g < NCFG; g++) begin
                for (int c = 0; c < 4; c++) begin
                    bit stable;
                    if (m_pend[g][c] && !m_os[g][c]) begin
                        m_start[g][c] = cycle;
                        m_last[g][c]  = cycle + P_TAB[g] - 1;
                    end
                    m_pend[g][c] = 1'b0;
                    stable = 1'b1;
                    for (int j = 2; j <= D_TAB[g] + 1; j++)
                        if (hist[c][j] == m_level[g][c]) stable = 1'b0;
                    if (stable) begin
                        m_level[g][c] = !m_level[g][c];
                        m_pend[g][c]  = m_level[g][c] ? (M_TAB[g] != 1)
                                                      : (M_TAB[g] == 1 || M_TAB[g] == 2);
                    end
                    m_os[g][c] = (cycle >= m_start[g][c]) && (cycle <= m_last[g][c]);
                end
            end
        end
    endtask

    task automatic compareAll();
        for (int g = 0; g < NCFG; g++) begin
            logic [3:0] exp_os, exp_lv;
            for (int c = 0; c < 4; c++) begin
                exp_os[c] = m_os[g][c];
                exp_lv[c] = m_level[g][c];
            end
            checkOutput($sformatf("cfg%0d OneShot", g), {28'b0, dut_os[g]}, {28'b0, exp_os});
            checkOutput($sformatf("cfg%0d Level", g), {28'b0, dut_level[g]}, {28'b0, exp_lv});
            checkOutput($sformatf("cfg%0d Busy", g), {31'b0, dut_busy[g]}, {31'b0, |exp_os});
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] inp);
        @(negedge clock);
        reset       = rst;
        input_pulse = inp;
        @(posedge clock);
        cycle++;
        modelStep(rst, inp);
        #1;
        compareAll();
    endtask

    initial begin
        int cap, lvl_seen, os_seen, os_count, busy_count, glitch_seen, rel, os3_seen;
        logic [3:0] rnd;
        reset       = 1'b1;
        input_pulse = 4'b0000;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0000);
        checkOutput("reset OneShot", {28'b0, dut_os[0] | dut_os[1] | dut_os[2] | dut_os[3]}, 32'h0);
        checkOutput("reset Level", {28'b0, dut_level[0] | dut_level[1] | dut_level[2] | dut_level[3]}, 32'h0);

        // Single channel rise and its latency on the D=4, P=1 instance.
        cap = cycle + 1;
        lvl_seen = -1; os_seen = -1; os_count = 0; busy_count = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 4'b0001);
            if (lvl_seen < 0 && dut_level[0][0]) lvl_seen = cycle;
            if (os_seen < 0 && dut_os[0][0]) os_seen = cycle;
            if (dut_os[0][0]) os_count++;
            if (dut_busy[0]) busy_count++;
        end
        checkOutput("level latency", lvl_seen - cap, 32'd5);
        checkOutput("oneshot latency", os_seen - cap, 32'd6);
        checkOutput("oneshot width", os_count, 32'd1);
        checkOutput("busy width", busy_count, 32'd1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 4'b0000);

        // Three-clock glitch must be swallowed by the D=4 debouncer.
        glitch_seen = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, (i < 3) ? 4'b0010 : 4'b0000);
            if (dut_level[0][1] || dut_os[0][1]) glitch_seen++;
        end
        checkOutput("glitch ignored", glitch_seen, 32'd0);

        // All channels together.
        os_count = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, (i < 15) ? 4'b1111 : 4'b0000);
            if (dut_os[0] == 4'b1111) os_count++;
        end
        checkOutput("all channels pulse", os_count, 32'd1);

        // Second falling edge 4 clocks into an 8-clock pulse (D=1 instance).
        os_count = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, (i < 8 || i == 10 || i == 11) ? 4'b1000 : 4'b0000);
            if (dut_os[2][3]) os_count++;
        end
        checkOutput("no retrigger", os_count, 32'd8);

        // Reset in the second cycle of a P=5 pulse, input kept high.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b1111);
        checkOutput("pulse before reset", {28'b0, dut_os[3]}, 32'hf);
        applyStimulus(1'b1, 4'b1111);
        checkOutput("oneshot at reset", {28'b0, dut_os[3]}, 32'h0);
        rel = cycle + 1;
        os3_seen = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 4'b1111);
            if (os3_seen < 0 && dut_os[3][0]) os3_seen = cycle;
        end
        checkOutput("pulse after release", os3_seen - rel, 32'd4);

        // Long hold: no further pulses expected.
        os_count = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 4'b1111);
            if (dut_busy[1]) os_count++;
        end
        checkOutput("hold no pulses", os_count, 32'd0);

        // Random bouncing inputs with occasional resets.
        rnd = 4'b1111;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) rnd[c] = ~rnd[c];
            applyStimulus($urandom_range(0, 299) == 0, rnd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
